// File: rtl/rx_dco_cal_seq.sv
// rx_dco_cal_seq: steps the RX DC-offset loops one channel at a time and flags RSSI overload per channel.
// Latency: settings bus outputs are registered, one cycle from host strobe to out_strobe.
// Backpressure: host writes always win the bus; a sequencer write waits for a cycle with no host strobe.
// Optional abort (host CTRL write with bit 31 while busy) is built only when DCO_CAL_ABORT_EN is defined.

`ifndef FR_DC_OFFSET_CL_EN
`define FR_DC_OFFSET_CL_EN 7'd40
`endif

module rx_dco_cal_seq #(
  parameter logic [6:0] CTRL_ADDR   = 7'd100,
  parameter logic [6:0] DCO_EN_ADDR = `FR_DC_OFFSET_CL_EN
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic [31:0] rssi_0,
  input  logic [31:0] rssi_1,
  input  logic [31:0] rssi_2,
  input  logic [31:0] rssi_3,
  output logic [6:0]  out_addr,
  output logic [31:0] out_data,
  output logic        out_strobe,
  output logic        busy,
  output logic        done,
  output logic [3:0]  fail
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_EN  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_WR_DIS = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [19:0] cnt_q, cnt_d;
  logic        wr_done_q, wr_done_d;
  logic        start_pend_q, start_pend_d;
  logic [3:0]  cfg_mask_q, cfg_mask_d;
  logic [4:0]  cfg_exp_q, cfg_exp_d;
  logic [15:0] cfg_limit_q, cfg_limit_d;
  logic [3:0]  run_mask_q, run_mask_d;
  logic [4:0]  run_exp_q, run_exp_d;
  logic [15:0] run_limit_q, run_limit_d;
  logic [3:0]  shadow_q, shadow_d;
  logic [6:0]  out_addr_q, out_addr_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_strobe_q, out_strobe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  fail_q, fail_d;

  logic        host_ctrl;
  logic        host_dco;
  logic        seq_free;
  logic        aborting;
  logic [15:0] rssi_over;
  logic [19:0] settle_last;
  logic [1:0]  first_ch;
  logic        nxt_found;
  logic [1:0]  nxt_ch;
  logic        unused_bits;

  assign host_ctrl   = serial_strobe && (serial_addr == CTRL_ADDR);
  assign host_dco    = serial_strobe && (serial_addr == DCO_EN_ADDR);
  // A pending sequencer write may go out only when the host is silent this cycle.
  assign seq_free    = !serial_strobe && !wr_done_q;
  assign settle_last = 20'((21'd1 << run_exp_q) - 21'd1);
  assign unused_bits = ^{serial_data[15:9], rssi_0[15:0], rssi_1[15:0], rssi_2[15:0], rssi_3[15:0]};

`ifdef DCO_CAL_ABORT_EN
  logic abort_q, abort_d;
  assign aborting = abort_q;
`else
  assign aborting = 1'b0;
`endif

  // Overload count of the channel currently being calibrated.
  always_comb begin
    rssi_over = rssi_0[31:16];
    case (ch_q)
      2'd1:    rssi_over = rssi_1[31:16];
      2'd2:    rssi_over = rssi_2[31:16];
      2'd3:    rssi_over = rssi_3[31:16];
      default: rssi_over = rssi_0[31:16];
    endcase
  end

  // Lowest set bit of the staged mask, and next set bit above ch in the running mask.
  always_comb begin
    first_ch  = 2'd0;
    nxt_found = 1'b0;
    nxt_ch    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cfg_mask_q[i]) first_ch = 2'(i);
      if (run_mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = 2'(i);
      end
    end
  end

  // Bus arbitration, control/shadow capture and sequencer FSM next state.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    wr_done_d    = wr_done_q;
    start_pend_d = start_pend_q;
    cfg_mask_d   = cfg_mask_q;
    cfg_exp_d    = cfg_exp_q;
    cfg_limit_d  = cfg_limit_q;
    run_mask_d   = run_mask_q;
    run_exp_d    = run_exp_q;
    run_limit_d  = run_limit_q;
    shadow_d     = shadow_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_strobe_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fail_d       = fail_q;
`ifdef DCO_CAL_ABORT_EN
    abort_d      = abort_q;
`endif

    if (serial_strobe) begin
      out_addr_d   = serial_addr;
      out_data_d   = serial_data;
      out_strobe_d = 1'b1;
    end
    // Start and abort bits overlay the top of the ovl_limit field; the word is taken as written.
    if (host_ctrl) begin
      cfg_mask_d  = serial_data[3:0];
      cfg_exp_d   = (serial_data[8:4] > 5'd20) ? 5'd20 : serial_data[8:4];
      cfg_limit_d = serial_data[31:16];
      if (serial_data[30] && !busy_q) start_pend_d = 1'b1;
    end
    if (host_dco) shadow_d = serial_data[3:0];

    case (state_q)
      S_IDLE: begin
        if (enable && start_pend_q) begin
          start_pend_d = 1'b0;
          if (cfg_mask_q != 4'd0) begin
            busy_d      = 1'b1;
            fail_d      = 4'd0;
            ch_d        = first_ch;
            run_mask_d  = cfg_mask_q;
            run_exp_d   = cfg_exp_q;
            run_limit_d = cfg_limit_q;
            wr_done_d   = 1'b0;
            state_d     = S_WR_EN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WR_EN: begin
        if (seq_free) begin
          out_addr_d   = DCO_EN_ADDR;
          out_data_d   = {28'd0, shadow_q | (4'd1 << ch_q)};
          out_strobe_d = 1'b1;
          wr_done_d    = 1'b1;
        end
        if (enable && (wr_done_q || seq_free)) begin
          state_d   = S_SETTLE;
          cnt_d     = 20'd0;
          wr_done_d = 1'b0;
        end
      end
      S_SETTLE: begin
        if (enable) begin
          if (cnt_q == settle_last) begin
            fail_d[ch_q] = (rssi_over > run_limit_q);
            wr_done_d    = 1'b0;
            state_d      = S_WR_DIS;
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
      end
      S_WR_DIS: begin
        if (seq_free) begin
          out_addr_d   = DCO_EN_ADDR;
          out_data_d   = {28'd0, shadow_q};
          out_strobe_d = 1'b1;
          wr_done_d    = 1'b1;
        end
        if (enable && (wr_done_q || seq_free)) begin
          wr_done_d = 1'b0;
          state_d   = aborting ? S_DONE : S_NEXT;
        end
      end
      S_NEXT: begin
        if (enable) begin
          if (nxt_found) begin
            ch_d      = nxt_ch;
            wr_done_d = 1'b0;
            state_d   = S_WR_EN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (enable) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef DCO_CAL_ABORT_EN
          abort_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef DCO_CAL_ABORT_EN
    // Abort jumps straight to the restore write, unless that write is already under way.
    if (host_ctrl && serial_data[31] && busy_q && (state_q != S_DONE)) begin
      abort_d = 1'b1;
      if (state_q != S_WR_DIS) begin
        state_d   = S_WR_DIS;
        wr_done_d = 1'b0;
      end
    end
`endif
  end

  // State registers; reset drops any run in flight without a restore write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ch_q         <= 2'd0;
      cnt_q        <= 20'd0;
      wr_done_q    <= 1'b0;
      start_pend_q <= 1'b0;
      cfg_mask_q   <= 4'd0;
      cfg_exp_q    <= 5'd0;
      cfg_limit_q  <= 16'd0;
      run_mask_q   <= 4'd0;
      run_exp_q    <= 5'd0;
      run_limit_q  <= 16'd0;
      shadow_q     <= 4'd0;
      out_addr_q   <= 7'd0;
      out_data_q   <= 32'd0;
      out_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 4'd0;
`ifdef DCO_CAL_ABORT_EN
      abort_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      wr_done_q    <= wr_done_d;
      start_pend_q <= start_pend_d;
      cfg_mask_q   <= cfg_mask_d;
      cfg_exp_q    <= cfg_exp_d;
      cfg_limit_q  <= cfg_limit_d;
      run_mask_q   <= run_mask_d;
      run_exp_q    <= run_exp_d;
      run_limit_q  <= run_limit_d;
      shadow_q     <= shadow_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
`ifdef DCO_CAL_ABORT_EN
      abort_q      <= abort_d;
`endif
    end
  end

  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;

endmodule
